// File: rtl/memory_stage_lsu.sv
// Load/store memory stage: variable-latency data-memory handshake, sub-word lanes,
// load extension, misalignment detection, stall generation and the M->W register.
module memory_stage_lsu #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic                  i_mem_re,
  input  logic                  i_mem_we,
  input  logic [1:0]            i_mem_size,
  input  logic                  i_mem_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
  input  logic [ADDR_WIDTH-1:0] i_pc_target,
  input  logic [ADDR_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [DATA_WIDTH-1:0] i_imm_ext,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic [2:0]            i_result_src,
  input  logic                  i_reg_we,
  output logic                  o_stall,
  output logic                  o_misalign,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [ADDR_WIDTH-1:0] o_alu_result,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_valid_w,
  output logic                  o_reg_we,
  output logic [2:0]            o_result_src,
  output logic [REG_ADDR_W-1:0] o_rd_addr_preg,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  output logic [ADDR_WIDTH-1:0] o_pc_target,
  output logic [DATA_WIDTH-1:0] o_imm_ext,
  output logic [ADDR_WIDTH-1:0] o_alu_result_preg,
  output logic [DATA_WIDTH-1:0] o_read_data
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFS_W = $clog2(NB);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic              kill_q;
  logic [OFS_W-1:0]  offset;
  logic [3:0]        size_bytes;
  logic [6:0]        size_bits;
  logic [OFS_W-1:0]  align_mask;
  logic              mem_op;
  logic              access;
  logic [NB-1:0]     be_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic              sign;
  logic [DATA_WIDTH-1:0] load_ext;
  logic              wb_valid;

  assign offset     = i_alu_result[OFS_W-1:0];
  assign size_bytes = 4'd1 << i_mem_size;
  assign size_bits  = {size_bytes, 3'b000};
  assign align_mask = OFS_W'(size_bytes - 4'd1);
  assign mem_op     = i_valid & (i_mem_re | i_mem_we);

  // A double access cannot fit a 32-bit bus, so it is treated as a fault there.
  assign o_misalign = mem_op & ((|(offset & align_mask)) |
                                ((i_mem_size == 2'b11) && (DATA_WIDTH == 32)));
  assign access     = mem_op & ~i_flush & ~o_misalign;

  assign o_mem_req  = ((state == IDLE) & access) | (state == WAIT);
  assign o_stall    = o_mem_req & ~i_mem_ack;

  assign o_rd_addr    = i_rd_addr;
  assign o_alu_result = i_alu_result;

  assign o_mem_we    = i_mem_we;
  assign o_mem_addr  = {i_alu_result[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
  assign o_mem_be    = be_mask << offset;
  assign o_mem_wdata = i_write_data << {offset, 3'b000};

  // NOTE: every always_comb output is fully assigned on each path (loops cover all bits,
  // case has a default), so no latch can be inferred.
  always_comb begin
    for (int i = 0; i < NB; i++) be_mask[i] = (4'(i) < size_bytes);
  end

  assign shifted = i_mem_rdata >> {offset, 3'b000};

  always_comb begin
    case (i_mem_size)
      2'b00:   sign = shifted[7];
      2'b01:   sign = shifted[15];
      2'b10:   sign = shifted[31];
      default: sign = shifted[DATA_WIDTH-1];
    endcase
    for (int i = 0; i < DATA_WIDTH; i++)
      load_ext[i] = (7'(i) < size_bits) ? shifted[i] : (sign & ~i_mem_unsigned);
  end

  assign wb_valid = i_valid & ~i_flush & ~kill_q & ~o_misalign;

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      kill_q            <= 1'b0;
      o_valid_w         <= 1'b0;
      o_reg_we          <= 1'b0;
      o_result_src      <= '0;
      o_rd_addr_preg    <= '0;
      o_pc_plus4        <= '0;
      o_pc_target       <= '0;
      o_imm_ext         <= '0;
      o_alu_result_preg <= '0;
      o_read_data       <= '0;
    end else begin
      case (state)
        IDLE: if (access && !i_mem_ack) state <= WAIT;
        WAIT: begin
          // A flush cannot cancel an issued request; remember it and bubble the result.
          if (i_mem_ack) begin
            state  <= IDLE;
            kill_q <= 1'b0;
          end else if (i_flush) begin
            kill_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (!o_stall) begin
        o_valid_w         <= wb_valid;
        o_reg_we          <= i_reg_we & wb_valid;
        o_result_src      <= i_result_src;
        o_rd_addr_preg    <= i_rd_addr;
        o_pc_plus4        <= i_pc_plus4;
        o_pc_target       <= i_pc_target;
        o_imm_ext         <= i_imm_ext;
        o_alu_result_preg <= i_alu_result;
        o_read_data       <= i_mem_re ? load_ext : '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Self-checking bench for memory_stage_lsu: directed test-plan steps, then random
// accesses against a byte-addressed reference memory and a latency-programmable responder.
module tb_memory_stage_lsu;

  logic        clk = 1'b0;
  logic        i_rst_n, i_valid, i_flush, i_mem_re, i_mem_we, i_mem_unsigned;
  logic [1:0]  i_mem_size;
  logic [63:0] i_pc_plus4, i_pc_target, i_alu_result, i_write_data, i_imm_ext;
  logic [4:0]  i_rd_addr;
  logic [2:0]  i_result_src;
  logic        i_reg_we, i_mem_ack;
  logic [63:0] i_mem_rdata;
  logic        o_stall, o_misalign, o_mem_req, o_mem_we;
  logic [4:0]  o_rd_addr, o_rd_addr_preg;
  logic [63:0] o_alu_result, o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_be;
  logic        o_valid_w, o_reg_we;
  logic [2:0]  o_result_src;
  logic [63:0] o_pc_plus4, o_pc_target, o_imm_ext, o_alu_result_preg, o_read_data;

  memory_stage_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .REG_ADDR_W(5)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_flush(i_flush),
    .i_mem_re(i_mem_re), .i_mem_we(i_mem_we), .i_mem_size(i_mem_size),
    .i_mem_unsigned(i_mem_unsigned), .i_pc_plus4(i_pc_plus4), .i_pc_target(i_pc_target),
    .i_alu_result(i_alu_result), .i_write_data(i_write_data), .i_imm_ext(i_imm_ext),
    .i_rd_addr(i_rd_addr), .i_result_src(i_result_src), .i_reg_we(i_reg_we),
    .o_stall(o_stall), .o_misalign(o_misalign), .o_rd_addr(o_rd_addr),
    .o_alu_result(o_alu_result), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_valid_w(o_valid_w),
    .o_reg_we(o_reg_we), .o_result_src(o_result_src), .o_rd_addr_preg(o_rd_addr_preg),
    .o_pc_plus4(o_pc_plus4), .o_pc_target(o_pc_target), .o_imm_ext(o_imm_ext),
    .o_alu_result_preg(o_alu_result_preg), .o_read_data(o_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] phys [16];       // memory device contents, written through the DUT lanes
  logic [7:0]  model_mem [128]; // reference image, written from the store rules directly
  logic [63:0] last_rd;
  logic [7:0]  last_be;
  logic [63:0] last_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [6:0] addr, input logic [1:0] size,
                                             input bit uns);
    int n;
    logic [63:0] v;
    n = 1 << size;
    v = '0;
    for (int b = 0; b < n; b++) v[8*b +: 8] = model_mem[(int'(addr) + b) % 128];
    if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  // One instruction through M. lat = cycles from first request to ack; flush_at > 0
  // pulses i_flush in that wait cycle.
  task automatic issue(input bit re, input bit we, input logic [1:0] size, input bit uns,
                       input logic [6:0] addr, input logic [63:0] wd,
                       input int lat, input int flush_at);
    int n, w, stalls, reqs;
    bit mem, misal, killed, rwe;
    logic [63:0] want_ld, want_wd, pc4, pct, imm, got_wd;
    logic [7:0]  want_be, got_be;
    logic [4:0]  rd;
    logic [2:0]  src;
    n       = 1 << size;
    w       = int'(addr[6:3]);
    mem     = re | we;
    misal   = mem && ((int'(addr) % n) != 0);
    want_ld = re ? model_load(addr, size, uns) : 64'd0;
    want_be = 8'(((1 << n) - 1) << int'(addr[2:0]));
    want_wd = wd << (8 * int'(addr[2:0]));
    pc4 = {$urandom, $urandom}; pct = {$urandom, $urandom}; imm = {$urandom, $urandom};
    rd  = 5'($urandom); src = 3'($urandom); rwe = 1'($urandom);
    i_valid = 1'b1; i_mem_re = re; i_mem_we = we; i_mem_size = size; i_mem_unsigned = uns;
    i_alu_result = {57'd0, addr}; i_write_data = wd; i_pc_plus4 = pc4; i_pc_target = pct;
    i_imm_ext = imm; i_rd_addr = rd; i_result_src = src; i_reg_we = rwe; i_flush = 1'b0;
    i_mem_ack = (lat == 0) && mem && !misal;
    i_mem_rdata = i_mem_ack ? phys[w] : {$urandom, $urandom};
    killed = 1'b0; stalls = 0; reqs = 0; got_be = '0; got_wd = '0;

    if (!mem || misal) begin
      @(negedge clk);
      check("misalign", o_misalign, misal);
      check("req_none", o_mem_req, 0);
      check("stall_none", o_stall, 0);
      check("fwd_rd", o_rd_addr, rd);
      check("fwd_alu", o_alu_result, {57'd0, addr});
      @(posedge clk); #1;
      check("valid_w", o_valid_w, !misal);
      check("reg_we", o_reg_we, rwe && !misal);
      if (!mem) check("read_data_nonload", o_read_data, 0);
      check("wb_pc4", o_pc_plus4, pc4);
    end else begin
      for (int c = 0; c <= lat; c++) begin
        if (c > 0) begin
          i_mem_ack   = (c == lat);
          i_mem_rdata = i_mem_ack ? phys[w] : {$urandom, $urandom};
          i_flush     = (c == flush_at);
          if (i_flush) killed = 1'b1;
        end
        @(negedge clk);
        if (c == 0) begin
          check("misalign_ok", o_misalign, 0);
          check("mem_we", o_mem_we, we);
          check("mem_addr", o_mem_addr, {57'd0, addr[6:3], 3'b000});
          check("mem_be", o_mem_be, want_be);
          check("mem_wdata", o_mem_wdata, want_wd);
          got_be = o_mem_be; got_wd = o_mem_wdata;
        end
        check("req", o_mem_req, 1);
        check("stall", o_stall, c != lat);
        if (o_stall) stalls++;
        if (o_mem_req) reqs++;
        @(posedge clk); #1;
      end
      check("stall_cycles", stalls, lat);
      check("req_cycles", reqs, lat + 1);
      check("valid_w", o_valid_w, !killed);
      check("reg_we", o_reg_we, rwe && !killed);
      check("read_data", o_read_data, want_ld);
      check("wb_rd", o_rd_addr_preg, rd);
      check("wb_src", o_result_src, src);
      check("wb_alu", o_alu_result_preg, {57'd0, addr});
      check("wb_imm", o_imm_ext, imm);
      check("wb_pct", o_pc_target, pct);
      if (we) begin
        for (int i = 0; i < 8; i++) if (got_be[i]) phys[w][8*i +: 8] = got_wd[8*i +: 8];
        for (int b = 0; b < n; b++) model_mem[int'(addr) + b] = wd[8*b +: 8];
      end
    end
    last_rd = o_read_data; last_be = got_be; last_wdata = got_wd;
    i_flush = 1'b0; i_mem_ack = 1'b0; i_valid = 1'b0;
  endtask

  initial begin
    for (int wi = 0; wi < 16; wi++) begin
      phys[wi] = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) model_mem[wi*8 + b] = phys[wi][8*b +: 8];
    end
    i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_mem_re = 1'b0; i_mem_we = 1'b0;
    i_mem_size = 2'b00; i_mem_unsigned = 1'b0; i_pc_plus4 = '0; i_pc_target = '0;
    i_alu_result = '0; i_write_data = '0; i_imm_ext = '0; i_rd_addr = '0;
    i_result_src = '0; i_reg_we = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_w", o_valid_w, 0);
    check("rst_reg_we", o_reg_we, 0);
    check("rst_read_data", o_read_data, 0);
    check("rst_pc4", o_pc_plus4, 0);
    check("rst_alu", o_alu_result_preg, 0);
    check("rst_req", o_mem_req, 0);
    check("rst_stall", o_stall, 0);
    i_rst_n = 1'b1;

    // Zero-wait store/load of a double
    issue(0, 1, 2'b11, 0, 7'h40, 64'h1122334455667788, 0, 0);
    check("plan_store_be", last_be, 8'hFF);
    issue(1, 0, 2'b11, 0, 7'h40, 64'd0, 0, 0);
    check("plan_load_double", last_rd, 64'h1122334455667788);

    // Sub-word load extension
    issue(0, 1, 2'b11, 0, 7'h40, 64'h0000000080000000, 0, 0);
    issue(1, 0, 2'b00, 0, 7'h43, 64'd0, 0, 0);
    check("plan_lb_signed", last_rd, 64'hFFFFFFFFFFFFFF80);
    issue(1, 0, 2'b00, 1, 7'h43, 64'd0, 0, 0);
    check("plan_lb_unsigned", last_rd, 64'h80);

    // Store half into the top lane
    issue(0, 1, 2'b01, 0, 7'h46, 64'h000000000000BEEF, 0, 0);
    check("plan_sh_be", last_be, 8'hC0);
    check("plan_sh_wdata", last_wdata[63:48], 16'hBEEF);

    // Misaligned word load, then a non-memory instruction
    issue(1, 0, 2'b10, 0, 7'h42, 64'd0, 0, 0);
    issue(0, 0, 2'b00, 0, 7'h13, 64'd0, 0, 0);

    // Three wait states
    issue(1, 0, 2'b10, 1, 7'h44, 64'd0, 3, 0);

    // Flushed store still commits; flush coinciding with ack bubbles a load
    issue(0, 1, 2'b11, 0, 7'h10, 64'hCAFEF00DDEADBEEF, 3, 1);
    issue(1, 0, 2'b11, 0, 7'h10, 64'd0, 2, 2);
    issue(1, 0, 2'b11, 0, 7'h10, 64'd0, 1, 0);
    check("plan_flushed_store_committed", last_rd, 64'hCAFEF00DDEADBEEF);

    // Reset while waiting for an ack
    i_valid = 1'b1; i_mem_re = 1'b1; i_mem_we = 1'b0; i_mem_size = 2'b11;
    i_alu_result = 64'h20; i_mem_ack = 1'b0;
    @(negedge clk);
    check("rstw_req_idle", o_mem_req, 1);
    @(posedge clk); #1;
    check("rstw_req_wait", o_mem_req, 1);
    check("rstw_stall_wait", o_stall, 1);
    i_rst_n = 1'b0; i_valid = 1'b0;
    @(posedge clk); #1;
    check("rstw_req_after", o_mem_req, 0);
    check("rstw_stall_after", o_stall, 0);
    check("rstw_valid_w", o_valid_w, 0);
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstw_req_released", o_mem_req, 0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      int kind, lat, fa;
      logic [1:0] sz;
      logic [6:0] ad;
      kind = int'($urandom % 5);
      sz   = 2'($urandom);
      ad   = 7'($urandom);
      if ($urandom % 4 != 0) ad = ad & 7'(~((1 << sz) - 1));
      lat  = int'($urandom % 4);
      fa   = (lat > 0 && $urandom % 5 == 0) ? int'($urandom_range(lat, 1)) : 0;
      issue(kind < 2, kind == 2 || kind == 3, sz, 1'($urandom), ad,
            {$urandom, $urandom}, lat, fa);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage_lsu.md
# memory_stage_lsu

Parametrised successor of the pipeline memory stage: a load/store unit with a variable-latency data-memory handshake, sub-word access sizes, sign/zero extension, misalignment detection, stall generation and a flushable memory→writeback pipeline register. It sits between the execute-stage register and the writeback stage. It drives an external data memory port and gives the hazard unit a stall and the forwarding network its outputs.

## Interface
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 64, data width; 32 or 64 only
- REG_ADDR_W, 5, register-address width
- NB = DATA_WIDTH/8 (derived, not overridable); OFS_W = log2(NB)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_valid  in  1  instruction present in M
- i_flush  in  1  kill instruction in M
- i_mem_re / i_mem_we  in  1 / 1  load / store
- i_mem_size  in  2  00 byte, 01 half, 10 word, 11 double
- i_mem_unsigned  in  1  zero-extend load
- i_pc_plus4, i_pc_target  in  ADDR_WIDTH each  passthrough
- i_alu_result  in  ADDR_WIDTH  effective address / ALU result
- i_write_data  in  DATA_WIDTH  store data, LSB-aligned
- i_imm_ext  in  DATA_WIDTH; i_rd_addr  in  REG_ADDR_W; i_result_src  in  3; i_reg_we  in  1
- o_stall  out  1  freeze F/D/E and hold M inputs
- o_misalign  out  1  combinational access-fault flag
- o_rd_addr, o_alu_result  out  combinational passthrough for forwarding
- o_mem_req  out  1; o_mem_we  out  1; o_mem_addr  out  ADDR_WIDTH, low OFS_W bits zero
- o_mem_be  out  NB; o_mem_wdata  out  DATA_WIDTH
- i_mem_ack  in  1; i_mem_rdata  in  DATA_WIDTH, valid in the ack cycle
- o_valid_w, o_reg_we, o_result_src, o_rd_addr_preg, o_pc_plus4, o_pc_target, o_imm_ext, o_alu_result_preg, o_read_data  out  writeback register

## Operation
- access = i_valid & (i_mem_re | i_mem_we) & !i_flush & !o_misalign.
- o_misalign = i_valid & (re|we) & the address is not a multiple of the size. Size 11 with DATA_WIDTH=32 is also a misalign. A misaligned access issues no request.
- FSM IDLE/WAIT:
  - IDLE→WAIT when access & !i_mem_ack.
  - WAIT→IDLE on i_mem_ack.
  - o_mem_req = (IDLE & access) | WAIT.
- o_stall = o_mem_req & !i_mem_ack.
- Store lanes: the offset is the low OFS_W address bits. o_mem_be is the size mask (1, 3, 0xF, 0xFF) shifted left by the offset. o_mem_wdata is i_write_data shifted left by 8×offset.
- Load: i_mem_rdata shifted right by 8×offset, truncated to the size, then sign-extended (or zero-extended if i_mem_unsigned) to DATA_WIDTH.
- The request fields (o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata) come combinationally from the inputs. Upstream holds the inputs stable while o_stall is high.
- i_flush in WAIT: the outstanding request is held until ack (a store still commits). The captured entry is a bubble. The kill is latched in an internal flag, which clears on ack.
- Writeback register loads every cycle with o_stall=0:
  - All data fields load unconditionally.
  - o_valid_w = i_valid & !flush & !killflag & !o_misalign; o_reg_we = i_reg_we & that term.
  - o_read_data = the extended load data (0 for non-loads).
- While o_stall=1 the writeback register holds; its downstream consumer treats it as unchanged.

## Timing
- Reset (i_rst_n=0 at an edge): state=IDLE, killflag=0, every writeback-register output = 0. o_mem_req drops from the cycle after the reset edge, regardless of any pending ack.
- Zero-wait memory (ack in the request cycle): no stall; 1 access/cycle; result appears in the writeback register 1 cycle later.
- Ack N cycles after the first request cycle: o_stall is high for N cycles. The writeback register loads on the ack edge.
- Simultaneous flush and ack in WAIT: the entry is a bubble; the FSM returns to IDLE.
- A non-memory instruction passes through with no stall and no request.

## Test plan
- Zero-wait: store double 0x1122334455667788 @0x40, then load double @0x40 on the next cycle.
  - Required: o_mem_be=0xFF on the store; o_read_data=0x1122334455667788 one cycle after the load; o_stall never high.
- Sub-word: load byte @0x43 with i_mem_rdata=0x00000000_80000000 → o_read_data=0xFFFF_FFFF_FFFF_FF80. The same access with unsigned → 0x80.
- Store half 0xBEEF @0x46 → o_mem_be=0xC0, o_mem_wdata[63:48]=0xBEEF.
- Misalign: load word @0x42 → o_misalign=1, o_mem_req=0, o_valid_w=0 next cycle; no stall.
- Wait states: ack delayed 3 cycles → o_stall high for exactly 3 cycles; o_mem_req high for 4; the writeback register captures the data on the ack edge.
- Flush in WAIT then ack: the store still acks and commits; o_valid_w=0, o_reg_we=0. Separately, reset asserted in WAIT: the FSM returns to IDLE and o_mem_req=0 at the next edge.
